// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - state_e      : responder FSM states (IDLE / WAIT / RESP)
//   - WORD_W, BE_W : data word and byte-enable widths
//   - LAT_MIN/MAX  : legal range of the LATENCY parameter
//   - idx_width()  : word-index width for a given storage depth
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_W  = 32;
  localparam int BE_W    = WORD_W / 8;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  // DEPTH is a power of two, so the index width is simply log2(DEPTH).
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit register storage.
// Ports:
//   clk    in  : rising-edge clock
//   we     in  : write strobe for the current index
//   idx    in  : word index shared by read and write
//   wdata  in  : write data
//   be     in  : byte-lane enables, bit i writes bits 8i+7:8i
//   rdata  out : combinational read of the word at idx
// Storage has no reset; contents survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];

  // Merge the enabled byte lanes into the addressed word only.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_d[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: request/response data-memory slave for the MIPS load/store
// port. Accepts one word access at a time, waits LATENCY cycles, performs the
// access, then holds the response until the initiator consumes it.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid / req_ready  : request handshake
//   req_we, req_addr,
//   req_wdata, req_be      : store flag, byte address, store data, byte enables
//   rsp_valid / rsp_ready  : response handshake
//   rsp_rdata, rsp_err     : load data (0 for stores/errors), reject flag
// Optional feature macro DMEM_ERR_CHECK_EN: when defined, misaligned or
// out-of-range addresses are rejected with rsp_err = 1 and no write. When
// undefined, rsp_err stays 0 and the word index wraps modulo DEPTH.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = idx_width(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              acc_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // The error decision is made on the incoming address and latched with the
  // request, so only the index bits need to be kept afterwards.
`ifdef DMEM_ERR_CHECK_EN
  assign acc_err = (req_addr[1:0] != 2'b00) || (req_addr[31:IW+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:IW+2], req_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (mem_rdata)
  );

  // Next-state, request latch, wait counter and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          err_d   = acc_err;
          idx_d   = req_addr[IW+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Store write and response capture share this edge; a rejected
          // access never touches storage.
          mem_we      = we_q && !err_q;
          rsp_rdata_d = (we_q || err_q) ? '0 : mem_rdata;
          rsp_err_d   = err_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder.
// Each issued access pushes its expected response, computed from a word-array
// reference model, into a queue; an independent monitor pops and compares on
// every response handshake.
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int passCount = 0;
  int checkCount = 0;

  logic [31:0] refMem [DEPTH];
  rsp_t        sbQueue [$];

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // 10 time-unit clock period
  always #5 clk = ~clk;

  // Single comparison point: every check funnels through here
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: rejected if misaligned or beyond storage when checking
  // is enabled; otherwise the word index is the address divided by four,
  // wrapped to the storage size.
  function automatic bit modelErr(input logic [31:0] addr);
`ifdef DMEM_ERR_CHECK_EN
    return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int modelIdx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  // Updates the model and returns the response the DUT must give
  function automatic rsp_t modelAccess(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be);
    rsp_t r;
    logic [31:0] mask;
    int idx;
    r.err = modelErr(addr);
    r.rdata = '0;
    idx = modelIdx(addr);
    if (!r.err) begin
      if (we) begin
        mask = '0;
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mask = mask | (32'hFF << (8 * i));
        end
        refMem[idx] = (refMem[idx] & ~mask) | (wdata & mask);
      end else begin
        r.rdata = refMem[idx];
      end
    end
    return r;
  endfunction

  // Issues one access, records its expected response and checks the
  // acceptance-to-response latency. Returns #1 after the edge where
  // rsp_valid rose; if rsp_ready is high it also waits for the handshake.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int waitCycles;
    int lat;
    waitCycles = 0;
    while (!req_ready && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("req_ready before issue", {31'd0, req_ready}, 32'd1);
    sbQueue.push_back(modelAccess(we, addr, wdata, be));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("response latency", lat, LATENCY);
    if (rsp_ready) begin
      waitCycles = 0;
      while (rsp_valid && waitCycles < 50) begin
        @(posedge clk);
        #1;
        waitCycles++;
      end
    end
  endtask

  // Monitor: compares every consumed response against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbQueue.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected response: got rdata 0x%08h err %0b, expected none", rsp_rdata, rsp_err);
      end else begin
        rsp_t exp;
        exp = sbQueue.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, exp.rdata);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp.err});
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] heldData;

    // Reset and check the idle outputs
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", {31'd0, rsp_err}, 32'd0);

    // Define every word so the model and storage agree before any load
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF);
    end

    // Full-word store then load back
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);

    // Partial byte-enable merge, plus a be=0 no-op store
    applyStimulus(1'b1, 32'h20, 32'h00000000, 4'hF);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF);
    checkOutput("model merge 0x20", refMem[8], 32'h00BB00DD);

    // Response backpressure: data held, no new request accepted
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    heldData = refMem[modelIdx(32'h10)];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("held rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("held rsp_rdata", rsp_rdata, heldData);
      checkOutput("held req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("req_ready after release", {31'd0, req_ready}, 32'd1);

`ifdef DMEM_ERR_CHECK_EN
    // Misaligned and out-of-range stores are rejected and write nothing
    applyStimulus(1'b1, 32'h13, 32'hCAFEF00D, 4'hF);
    applyStimulus(1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
`else
    // Out-of-range address wraps onto the low words
    applyStimulus(1'b1, 32'(DEPTH * 4 + 8), 32'h12345678, 4'hF);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0);
    checkOutput("model wrap 0x08", refMem[2], 32'h12345678);
`endif

    // Reset during WAIT of a store discards it
    applyStimulus(1'b1, 32'h30, 32'h11111111, 4'hF);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h99999999;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("post-abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("post-abort req_ready", {31'd0, req_ready}, 32'd1);
    repeat (LATENCY + 1) @(posedge clk);
    #1;
    checkOutput("post-abort idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0);

    // Randomized mix of loads and stores
    for (int n = 0; n < 60; n++) begin
`ifdef DMEM_ERR_CHECK_EN
      a = 32'($urandom_range(0, DEPTH * 8 - 1));
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
`else
      a = $urandom;
`endif
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", sbQueue.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
